// File: rtl/fifo_puerto.sv
// fifo_puerto: first-word-fall-through register FIFO with occupancy count, threshold flags and a sticky over/underflow error (in: clk, reset, push, pop, data_in, umbral_af, umbral_ae; out: data_out, empty, full, almostfull, almostempty, count, error)
module fifo_puerto #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic [PTR_W:0]            umbral_af,
  input  logic [PTR_W:0]            umbral_ae,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almostfull,
  output logic                      almostempty,
  output logic [PTR_W:0]            count,
  output logic                      error
);
  logic [FIFO_WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic pop_ok, push_ok;
  assign empty = count == '0;
  assign full = count == (PTR_W+1)'(FIFO_DEPTH);
  assign almostfull = count >= umbral_af;
  assign almostempty = count <= umbral_ae;
  assign data_out = empty ? '0 : mem[rd_ptr];
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  always_ff @(posedge clk)
    if (push_ok && !reset) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      if ((push & ~push_ok) | (pop & empty)) error <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_puerto.sv
// tb_fifo_puerto: queue-model checker plus directed scenarios for fifo_puerto
module tb_fifo_puerto;
  localparam int W = 10;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [3:0] umbral_af = 4'd6;
  logic [3:0] umbral_ae = 4'd1;
  logic [W-1:0] data_out;
  logic empty, full, almostfull, almostempty, error;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  bit m_err = 1'b0;

  fifo_puerto #(.FIFO_WORD_SIZE(W), .FIFO_DEPTH(D), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae), .data_out(data_out),
    .empty(empty), .full(full), .almostfull(almostfull),
    .almostempty(almostempty), .count(count), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      bit po, pu;
      po = pop && q.size() > 0;
      pu = push && (q.size() < D || po);
      if ((pop && q.size() == 0) || (push && !pu)) m_err = 1'b1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("m_count", 32'(count), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_full", 32'(full), 32'(n == D));
    chk("m_almostfull", 32'(almostfull), 32'(n >= int'(umbral_af)));
    chk("m_almostempty", 32'(almostempty), 32'(n <= int'(umbral_ae)));
    chk("m_data_out", 32'(data_out), n > 0 ? 32'(q[0]) : 32'd0);
    chk("m_error", 32'(error), 32'(m_err));
  end

  task automatic cyc(input logic pu, input logic po, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    push = pu;
    pop = po;
    data_in = d;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_af", 32'(almostfull), 32'd0);
    chk("rst_ae", 32'(almostempty), 32'd1);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 0, 10'h3A1);
    cyc(1, 0, 10'h0F2);
    cyc(1, 0, 10'h155);
    cyc(0, 1, '0);
    chk("fwft_0", 32'(data_out), 32'h3A1);
    cyc(0, 1, '0);
    chk("fwft_1", 32'(data_out), 32'h0F2);
    cyc(0, 1, '0);
    chk("fwft_2", 32'(data_out), 32'h155);
    cyc(0, 0, '0);
    chk("fwft_empty", 32'(empty), 32'd1);
    for (int i = 0; i < D; i++) begin
      cyc(1, 0, W'(i * 37 + 5));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almostfull), 32'(i >= 6));
    end
    cyc(0, 0, '0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_af8", 32'(almostfull), 32'd1);
    chk("fill_head", 32'(data_out), 32'd5);
    #1 umbral_af = 4'd0;
    #1 chk("af_zero", 32'(almostfull), 32'd1);
    umbral_af = 4'd9;
    #1 chk("af_over", 32'(almostfull), 32'd0);
    umbral_af = 4'd8;
    #1 chk("af_eq", 32'(almostfull), 32'd1);
    umbral_ae = 4'd8;
    #1 chk("ae_eq", 32'(almostempty), 32'd1);
    umbral_ae = 4'd7;
    #1 chk("ae_below", 32'(almostempty), 32'd0);
    umbral_af = 4'd6;
    umbral_ae = 4'd1;
    for (int i = 0; i < 20; i++) cyc(1, 1, W'(100 + i));
    cyc(0, 0, '0);
    chk("wrap_count", 32'(count), 32'd8);
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_error", 32'(error), 32'd0);
    chk("wrap_head", 32'(data_out), 32'd112);
    cyc(1, 0, 10'h3FF);
    cyc(0, 0, '0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 0; i < D; i++) begin
      cyc(0, 1, '0);
      chk("drain", 32'(data_out), 32'(112 + i));
    end
    cyc(1, 1, 10'h200);
    chk("unf_pre_empty", 32'(empty), 32'd1);
    cyc(0, 0, '0);
    chk("unf_count", 32'(count), 32'd1);
    chk("unf_dout", 32'(data_out), 32'h200);
    chk("unf_error", 32'(error), 32'd1);
    cyc(0, 1, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, W'(10'h050 + i));
    cyc(0, 0, '0);
    chk("mid_count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_error", 32'(error), 32'd0);
    chk("arst_dout", 32'(data_out), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 0, 10'h0AB);
    cyc(0, 1, '0);
    chk("post_dout", 32'(data_out), 32'h0AB);
    chk("post_count", 32'(count), 32'd1);
    cyc(0, 0, '0);
    chk("post_empty", 32'(empty), 32'd1);
    chk("post_error", 32'(error), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_puerto.md
FIFO_PUERTO -- requirements
Module: fifo_puerto

Interface
REQ-001 Parameter FIFO_WORD_SIZE, default 10, width of each stored word.
REQ-002 Parameter FIFO_DEPTH, default 8, number of entries; SHALL be a power of two, at least 4.
REQ-003 Parameter PTR_W, default 3, pointer width; SHALL equal log2(FIFO_DEPTH).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 push  in  1  write request from the upstream writer (arbiter push_pX side).
REQ-007 pop  in  1  read request from the downstream reader (arbiter pop_pX side).
REQ-008 data_in  in  FIFO_WORD_SIZE  word to write when push is accepted.
REQ-009 umbral_af  in  PTR_W+1  almost-full threshold (occupancy count).
REQ-010 umbral_ae  in  PTR_W+1  almost-empty threshold (occupancy count).
REQ-011 data_out  out  FIFO_WORD_SIZE  head word; first-word-fall-through.
REQ-012 empty  out  1  occupancy == 0.
REQ-013 full  out  1  occupancy == FIFO_DEPTH.
REQ-014 almostfull  out  1  occupancy >= umbral_af.
REQ-015 almostempty  out  1  occupancy <= umbral_ae.
REQ-016 count  out  PTR_W+1  current occupancy.
REQ-017 error  out  1  sticky flag for overflow or underflow.

Function
REQ-018 Storage SHALL be a FIFO_DEPTH x FIFO_WORD_SIZE register array with wr_ptr and rd_ptr of PTR_W bits that wrap modulo FIFO_DEPTH, plus a PTR_W+1 occupancy counter.
REQ-019 data_out SHALL equal mem[rd_ptr] combinationally whenever empty=0, so the reader can sample the word in the same cycle it asserts pop; when empty=1, data_out SHALL be 0.
REQ-020 A push is accepted when push=1 and either full=0, or full=1 with a pop accepted in the same cycle; on acceptance mem[wr_ptr] <= data_in and wr_ptr increments.
REQ-021 A pop is accepted when pop=1 and empty=0; on acceptance rd_ptr increments.
REQ-022 count SHALL rise by 1 on a push-only cycle, fall by 1 on a pop-only cycle, and hold when both or neither are accepted.
REQ-023 push=1 with full=1 and no accepted pop SHALL be ignored: memory, pointers and count unchanged, and error SHALL set.
REQ-024 pop=1 with empty=1 SHALL be ignored and error SHALL set; if push=1 in the same cycle, the push SHALL still be accepted.
REQ-025 error SHALL remain 1 until reset.
REQ-026 empty, full, almostfull and almostempty SHALL be decoded combinationally from the count register, so they change in the cycle after the causing edge; they SHALL respond immediately to changes on umbral_af and umbral_ae.
REQ-027 umbral_af = 0 SHALL force almostfull=1; umbral_af > FIFO_DEPTH SHALL force almostfull=0.
REQ-028 Pointer wrap from FIFO_DEPTH-1 to 0 SHALL preserve strict write order across any number of wraps.

Reset
REQ-029 While reset=1, asynchronously: wr_ptr=0, rd_ptr=0, count=0, error=0, so empty=1, full=0, data_out=0, almostempty=1, and almostfull=(umbral_af==0).
REQ-030 Memory contents are not reset; no stale word SHALL be visible on data_out after reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; push and pop SHALL be ignored while reset=1.

Verification
REQ-032 Reset with umbral_af=6, umbral_ae=1 -> empty=1, full=0, count=0, almostfull=0, almostempty=1, data_out=0, error=0.
REQ-033 Push 0x3A1, 0x0F2, 0x155 on consecutive cycles, then pop 3 -> data_out shows 0x3A1, 0x0F2, 0x155 in that order, each in the same cycle as its pop; empty=1 after the third pop.
REQ-034 Push 8 words with umbral_af=6 -> almostfull=1 once count=6, full=1 at count=8; a 9th push is dropped and error=1; the 8 popped words equal the inputs.
REQ-035 Hold full and assert push=1 and pop=1 for 20 cycles -> count stays 8, full stays 1, error stays 0, output order is preserved across pointer wrap.
REQ-036 Pop on empty together with push of 0x200 -> error=1, count=1, data_out=0x200 on the next cycle.
REQ-037 Load 5 words, assert reset for 1 cycle mid-stream -> count=0, empty=1, error=0 immediately; the next push/pop pair returns only the new word.
